// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared entry type, alignment constants and sizing helper for instruction fetch
package fetch_pkg;
   localparam int FETCH_ADDR_W  = 64;
   localparam int FETCH_INSTR_W = 32;
   localparam int INSTR_BYTES   = 4;
   localparam logic [FETCH_ADDR_W-1:0] ALIGN_MASK = ~FETCH_ADDR_W'(INSTR_BYTES - 1);

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0]  pc;
      logic [FETCH_INSTR_W-1:0] instr;
      logic                     err;
   } fetch_entry_t;

   function automatic int count_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush; serves as fetch output buffer and PC tag queue
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  entry_t                    push_data,
   input  logic                      pop,
   input  logic                      flush,
   output entry_t                    head,
   output logic [count_w(DEPTH)-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = count_w(DEPTH);

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   // flush wins over a same-cycle push or pop
   assign do_push = push && !flush;
   assign do_pop  = pop && !flush && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   overflow_check: assert property (@(posedge clk) disable iff (rst)
      !(do_push && !do_pop && count == CNT_W'(DEPTH)));
endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC owner: credit-limited in-order requests, tagged response buffer, redirect flush
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W     = 64,
   parameter int                INSTR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               mem_req_valid,
   output logic [ADDR_W-1:0]  mem_req_addr,
   input  logic               mem_req_ready,
   input  logic               mem_rsp_valid,
   input  logic [INSTR_W-1:0] mem_rsp_data,
   input  logic               mem_rsp_err,
   output logic               fetch_valid,
   output logic [ADDR_W-1:0]  fetch_pc,
   output logic [INSTR_W-1:0] fetch_instr,
   output logic               fetch_err,
   input  logic               fetch_ready
);
   localparam int CNT_W = count_w(FIFO_DEPTH);
   typedef logic [ADDR_W-1:0] addr_t;

   addr_t            pc;
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] tag_count;
   logic [CNT_W+1:0] credit_used;
   logic             accept;
   logic             dropping;
   logic             rsp_keep;
   addr_t            tag_pc;
   fetch_entry_t     rsp_entry;
   fetch_entry_t     head;

   // stale requests still hold a slot until their response drains
   assign credit_used   = (CNT_W+2)'(outstanding) + (CNT_W+2)'(drop_cnt) + (CNT_W+2)'(fifo_count);
   assign mem_req_valid = !reset && !redirect_valid && (credit_used < (CNT_W+2)'(FIFO_DEPTH));
   assign mem_req_addr  = pc;
   assign accept        = mem_req_valid && mem_req_ready;
   assign dropping      = drop_cnt != '0;
   assign rsp_keep      = mem_rsp_valid && !dropping && !redirect_valid;

   assign rsp_entry = '{pc: FETCH_ADDR_W'(tag_pc), instr: FETCH_INSTR_W'(mem_rsp_data), err: mem_rsp_err};

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(addr_t)) tag_queue (
      .clk       (clk_in),
      .rst       (reset),
      .push      (accept),
      .push_data (pc),
      .pop       (mem_rsp_valid && !dropping),
      .flush     (redirect_valid),
      .head      (tag_pc),
      .count     (tag_count)
   );

   fetch_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(fetch_entry_t)) out_buf (
      .clk       (clk_in),
      .rst       (reset),
      .push      (rsp_keep),
      .push_data (rsp_entry),
      .pop       (fetch_ready),
      .flush     (redirect_valid),
      .head      (head),
      .count     (fifo_count)
   );

   assign fetch_valid = fifo_count != '0;
   assign fetch_pc    = head.pc[ADDR_W-1:0];
   assign fetch_instr = head.instr[INSTR_W-1:0];
   assign fetch_err   = head.err;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else if (redirect_valid) begin
         // a response landing in the redirect cycle is itself stale
         pc          <= redirect_pc & ADDR_W'(ALIGN_MASK);
         outstanding <= '0;
         drop_cnt    <= drop_cnt + outstanding - CNT_W'(mem_rsp_valid);
      end else begin
         if (accept) pc <= pc + addr_t'(INSTR_BYTES);
         outstanding <= outstanding + CNT_W'(accept) - CNT_W'(mem_rsp_valid && !dropping);
         drop_cnt    <= drop_cnt - CNT_W'(mem_rsp_valid && dropping);
      end
   end

   tag_present_check: assert property (@(posedge clk_in) disable iff (reset)
      !(rsp_keep && tag_count == '0));
endmodule
